id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
Instruction-decode stage of the MIPS32 pipeline. It sits between the IF/ID latch and the execute unit and is the producer of the execute unit's operand interface: instr_type, aluop, rdata1, rdata2 and ext_imm.
It reads the register file, resolves EX/MEM forwarding, extends immediates and registers everything into the ID/EX pipeline register. The register has stall and flush control.

Parameters:
RESET_PC, 32'h0000_0000, value of ex_pc after reset or flush

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
id_valid  in  1  IF/ID holds a valid instruction
id_inst  in  32  instruction word
id_pc  in  32  instruction address
id_ready  out  1  stage accepts id_inst this cycle
raddr1  out  5  regfile read port 1 address (rs)
raddr2  out  5  regfile read port 2 address (rt)
rf_rdata1  in  32  regfile port 1 data (combinational)
rf_rdata2  in  32  regfile port 2 data (combinational)
fw_ex_wreg  in  1  EX-stage result will be written
fw_ex_waddr  in  5  EX-stage destination
fw_ex_wdata  in  32  EX-stage result
fw_mem_wreg  in  1  MEM-stage result will be written
fw_mem_waddr  in  5  MEM-stage destination
fw_mem_wdata  in  32  MEM-stage result
stall  in  1  downstream hold request
flush  in  1  kill instruction entering EX
ex_valid  out  1  ID/EX register holds a valid instruction
ex_pc  out  32  registered pc
instr_type  out  2  registered `type_r / `type_i
aluop  out  2  registered `aluop_or/_and/_add/_sub
rdata1  out  32  registered operand 1
rdata2  out  32  registered operand 2
ext_imm  out  32  registered extended immediate
ex_wreg  out  1  registered write-enable
ex_waddr  out  5  registered destination
ex_illegal  out  1  registered illegal-opcode flag

Behaviour:
- Encodings come from the shared definitions header macros (`type_*`, `aluop_*`).
- raddr1 = inst[25:21] and raddr2 = inst[20:16], combinational. id_ready = !stall.
- Decode (op = inst[31:26]):
  - ORI 001101: type_i, or, zero-extended imm, dest rt.
  - ANDI 001100: type_i, and, zero-extended imm, dest rt.
  - ADDI 001000 and ADDIU 001001: type_i, add, sign-extended imm, dest rt.
  - LUI 001111: type_i, or, imm<<16, rdata1 forced to 0, dest rt.
  - op 000000 with funct 100101 OR, 100100 AND, 100000/100001 ADD/ADDU, 100010/100011 SUB/SUBU: type_r, dest rd, ext_imm = 0.
  - inst == 0 (nop): wreg = 0, not illegal.
  - Anything else: wreg = 0, illegal = 1, aluop = or, operands still resolved.
- Operand resolution, per port:
  - Address 0 reads 0; it is never forwarded.
  - Otherwise, if fw_ex_wreg and the addresses match, use fw_ex_wdata.
  - Otherwise, if fw_mem_wreg and the addresses match, use fw_mem_wdata.
  - Otherwise use rf_rdata.
  - EX has priority over MEM.
- Write to destination 0 forces wreg = 0.
- Register update at posedge clk, in priority order:
  - rst: ex_valid, ex_wreg and ex_illegal = 0; all data outputs = 0; ex_pc = RESET_PC; instr_type = `type_i; aluop = `aluop_or.
  - flush: same values as reset (bubble). Flush wins over stall.
  - stall: all ID/EX outputs hold. id_ready = 0, so the instruction is not consumed.
  - Otherwise: load the decoded values. ex_valid = id_valid. When id_valid = 0, ex_wreg = 0 and ex_illegal = 0.
- Latency: 1 cycle from accepted id_inst to ex_* outputs.
- Operands are captured at load time only. While stalled they are not refreshed, so the upstream control stalls until any hazard resolves.
- Reset mid-stall: outputs clear on the next edge regardless of stall or flush.

Test Plan:
- Reset asserted for 2 cycles with stall = 1 and flush = 0 -> ex_valid = 0, ex_wreg = 0, ex_pc = 0, all data outputs 0, id_ready = 0 while stall is high.
- ORI $2,$1,0x8001 (34228001) with rf_rdata1 = 32'h0000_00F0 -> next cycle: type_i, aluop_or, rdata1 = F0, ext_imm = 0000_8001, ex_waddr = 2, ex_wreg = 1.
- ADDI $3,$0,-1 (2003FFFF) -> ext_imm = FFFF_FFFF, rdata1 = 0 even though rf_rdata1 is driven to DEADBEEF. LUI $4,0x1234 -> ext_imm = 1234_0000, rdata1 = 0.
- SUB $5,$6,$7 with fw_ex on $6 = 11, fw_mem on $6 = 22, fw_mem on $7 = 33, and regfile values 44 -> rdata1 = 11, rdata2 = 33, type_r, aluop_sub, waddr = 5.
- Stall held 3 cycles after loading ORI, with a different id_inst presented -> outputs unchanged and id_ready = 0. Flush and stall asserted together -> bubble on the next edge.
- Opcode 6'b111111 with id_valid = 1 -> ex_valid = 1, ex_illegal = 1, ex_wreg = 0. inst = 0 -> ex_illegal = 0, ex_wreg = 0.

Source files
------------

// File: rtl/id_stage.sv
// MIPS32 instruction-decode stage: regfile read, EX/MEM forwarding, immediate
// extension and the ID/EX pipeline register with stall and flush control.

`ifndef TYPE_R
`define TYPE_R    2'b00
`define TYPE_I    2'b01
`endif
`ifndef ALUOP_OR
`define ALUOP_OR  2'b00
`define ALUOP_AND 2'b01
`define ALUOP_ADD 2'b10
`define ALUOP_SUB 2'b11
`endif

module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_pc,
  output logic        id_ready,
  output logic [4:0]  raddr1,
  output logic [4:0]  raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        fw_ex_wreg,
  input  logic [4:0]  fw_ex_waddr,
  input  logic [31:0] fw_ex_wdata,
  input  logic        fw_mem_wreg,
  input  logic [4:0]  fw_mem_waddr,
  input  logic [31:0] fw_mem_wdata,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [1:0]  instr_type,
  output logic [1:0]  aluop,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] ext_imm,
  output logic        ex_wreg,
  output logic [4:0]  ex_waddr,
  output logic        ex_illegal
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  assign op    = id_inst[31:26];
  assign rs    = id_inst[25:21];
  assign rt    = id_inst[20:16];
  assign rd    = id_inst[15:11];
  assign funct = id_inst[5:0];
  assign imm   = id_inst[15:0];

  assign raddr1   = rs;
  assign raddr2   = rt;
  assign id_ready = !stall;

  // Register $0 is hardwired to zero and must never pick up a forwarded value.
  logic [31:0] opnd1, opnd2;
  assign opnd1 = (rs == 5'd0)                          ? 32'd0 :
                 (fw_ex_wreg  && fw_ex_waddr  == rs)   ? fw_ex_wdata :
                 (fw_mem_wreg && fw_mem_waddr == rs)   ? fw_mem_wdata : rf_rdata1;
  assign opnd2 = (rt == 5'd0)                          ? 32'd0 :
                 (fw_ex_wreg  && fw_ex_waddr  == rt)   ? fw_ex_wdata :
                 (fw_mem_wreg && fw_mem_waddr == rt)   ? fw_mem_wdata : rf_rdata2;

  logic [1:0]  d_type, d_aluop;
  logic [31:0] d_imm;
  logic [4:0]  d_dest;
  logic        d_wen, d_illegal, d_zero_rs, d_wreg;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    d_type    = `TYPE_I;
    d_aluop   = `ALUOP_OR;
    d_imm     = 32'd0;
    d_dest    = rt;
    d_wen     = 1'b0;
    d_illegal = 1'b0;
    d_zero_rs = 1'b0;
    unique case (op)
      OP_ORI:  begin d_imm = {16'd0, imm}; d_wen = 1'b1; end
      OP_ANDI: begin d_aluop = `ALUOP_AND; d_imm = {16'd0, imm}; d_wen = 1'b1; end
      OP_ADDI, OP_ADDIU: begin
        d_aluop = `ALUOP_ADD;
        d_imm   = {{16{imm[15]}}, imm};
        d_wen   = 1'b1;
      end
      OP_LUI:  begin d_imm = {imm, 16'd0}; d_zero_rs = 1'b1; d_wen = 1'b1; end
      OP_SPECIAL: begin
        if (id_inst != 32'd0) begin
          d_type = `TYPE_R;
          d_dest = rd;
          d_wen  = 1'b1;
          unique case (funct)
            FN_OR:           d_aluop = `ALUOP_OR;
            FN_AND:          d_aluop = `ALUOP_AND;
            FN_ADD, FN_ADDU: d_aluop = `ALUOP_ADD;
            FN_SUB, FN_SUBU: d_aluop = `ALUOP_SUB;
            default: begin
              d_type    = `TYPE_I;
              d_wen     = 1'b0;
              d_illegal = 1'b1;
            end
          endcase
        end
      end
      default: d_illegal = 1'b1;
    endcase
    d_wreg = d_wen && (d_dest != 5'd0);
  end

  // Flush loads the same bubble as reset; stall simply withholds the load.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst || flush) begin
      ex_valid   <= 1'b0;
      ex_pc      <= RESET_PC;
      instr_type <= `TYPE_I;
      aluop      <= `ALUOP_OR;
      rdata1     <= 32'd0;
      rdata2     <= 32'd0;
      ext_imm    <= 32'd0;
      ex_wreg    <= 1'b0;
      ex_waddr   <= 5'd0;
      ex_illegal <= 1'b0;
    end else if (!stall) begin
      ex_valid   <= id_valid;
      ex_pc      <= id_pc;
      instr_type <= d_type;
      aluop      <= d_aluop;
      rdata1     <= d_zero_rs ? 32'd0 : opnd1;
      rdata2     <= opnd2;
      ext_imm    <= d_imm;
      ex_wreg    <= id_valid && d_wreg;
      ex_waddr   <= d_dest;
      ex_illegal <= id_valid && d_illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed test-plan steps followed by randomized
// instructions, all checked against a behavioural decode model.

`ifndef TYPE_R
`define TYPE_R    2'b00
`define TYPE_I    2'b01
`endif
`ifndef ALUOP_OR
`define ALUOP_OR  2'b00
`define ALUOP_AND 2'b01
`define ALUOP_ADD 2'b10
`define ALUOP_SUB 2'b11
`endif

module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] id_inst, id_pc, rf_rdata1, rf_rdata2;
  logic        fw_ex_wreg, fw_mem_wreg;
  logic [4:0]  fw_ex_waddr, fw_mem_waddr;
  logic [31:0] fw_ex_wdata, fw_mem_wdata;
  logic        id_ready, ex_valid, ex_wreg, ex_illegal;
  logic [4:0]  raddr1, raddr2, ex_waddr;
  logic [31:0] ex_pc, rdata1, rdata2, ext_imm;
  logic [1:0]  instr_type, aluop;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_ready(id_ready), .raddr1(raddr1), .raddr2(raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fw_ex_wreg(fw_ex_wreg), .fw_ex_waddr(fw_ex_waddr), .fw_ex_wdata(fw_ex_wdata),
    .fw_mem_wreg(fw_mem_wreg), .fw_mem_waddr(fw_mem_waddr), .fw_mem_wdata(fw_mem_wdata),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .instr_type(instr_type), .aluop(aluop), .rdata1(rdata1), .rdata2(rdata2),
    .ext_imm(ext_imm), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_illegal(ex_illegal)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [1:0]  ty;
    logic [1:0]  alu;
    logic [31:0] r1, r2, imm;
    logic        wreg;
    logic [4:0]  waddr;
    logic        ill;
    logic        care_dec;  // type and immediate are defined
    logic        care_alu;  // aluop is defined
  } exp_t;

  exp_t expd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e = '{v: 1'b0, pc: 32'h0, ty: `TYPE_I, alu: `ALUOP_OR, r1: 32'h0, r2: 32'h0,
          imm: 32'h0, wreg: 1'b0, waddr: 5'd0, ill: 1'b0, care_dec: 1'b1, care_alu: 1'b1};
    return e;
  endfunction

  // Value an operand port should see: $0 reads zero, then EX, then MEM, then regfile.
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 32'h0;
    if (fw_ex_wreg && fw_ex_waddr == a) return fw_ex_wdata;
    if (fw_mem_wreg && fw_mem_waddr == a) return fw_mem_wdata;
    return rf;
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic [4:0]  rs, rt, rd;
    logic [15:0] im;
    logic [4:0]  dest;
    logic        writes;
    string       mnem;
    rs = id_inst[25:21]; rt = id_inst[20:16]; rd = id_inst[15:11]; im = id_inst[15:0];
    e = bubble();
    e.v = id_valid; e.pc = id_pc;
    e.r1 = operand(rs, rf_rdata1);
    e.r2 = operand(rt, rf_rdata2);
    writes = 1'b1; dest = rt;
    mnem = "ill";
    if (id_inst == 0) mnem = "nop";
    else if (id_inst[31:26] == 6'o15) mnem = "ori";
    else if (id_inst[31:26] == 6'o14) mnem = "andi";
    else if (id_inst[31:26] == 6'o10 || id_inst[31:26] == 6'o11) mnem = "addi";
    else if (id_inst[31:26] == 6'o17) mnem = "lui";
    else if (id_inst[31:26] == 0) begin
      if (id_inst[5:0] == 6'o45) mnem = "or";
      else if (id_inst[5:0] == 6'o44) mnem = "and";
      else if (id_inst[5:0] == 6'o40 || id_inst[5:0] == 6'o41) mnem = "add";
      else if (id_inst[5:0] == 6'o42 || id_inst[5:0] == 6'o43) mnem = "sub";
    end
    case (mnem)
      "ori":  e.imm = 32'(im);
      "andi": begin e.alu = `ALUOP_AND; e.imm = 32'(im); end
      "addi": begin e.alu = `ALUOP_ADD; e.imm = 32'($signed(im)); end
      "lui":  begin e.imm = 32'(im) * 32'h10000; e.r1 = 0; end
      "or", "and", "add", "sub": begin
        e.ty = `TYPE_R; dest = rd;
        e.alu = (mnem == "or") ? `ALUOP_OR : (mnem == "and") ? `ALUOP_AND :
                (mnem == "add") ? `ALUOP_ADD : `ALUOP_SUB;
      end
      "nop": begin writes = 1'b0; e.care_dec = 1'b0; e.care_alu = 1'b0; end
      default: begin writes = 1'b0; e.ill = id_valid; e.care_dec = 1'b0; end
    endcase
    e.wreg  = id_valid && writes && dest != 0;
    e.waddr = dest;
    return e;
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, ".ex_valid"},   32'(ex_valid),   32'(expd.v));
    chk({tag, ".ex_pc"},      ex_pc,           expd.pc);
    chk({tag, ".rdata1"},     rdata1,          expd.r1);
    chk({tag, ".rdata2"},     rdata2,          expd.r2);
    chk({tag, ".ex_wreg"},    32'(ex_wreg),    32'(expd.wreg));
    chk({tag, ".ex_illegal"}, 32'(ex_illegal), 32'(expd.ill));
    if (expd.care_alu) chk({tag, ".aluop"}, 32'(aluop), 32'(expd.alu));
    if (expd.care_dec) begin
      chk({tag, ".instr_type"}, 32'(instr_type), 32'(expd.ty));
      chk({tag, ".ext_imm"},    ext_imm,         expd.imm);
    end
    if (expd.wreg) chk({tag, ".ex_waddr"}, 32'(ex_waddr), 32'(expd.waddr));
  endtask

  // Inputs are already driven (just after an edge); check the combinational
  // outputs, predict the register update, clock once and compare.
  task automatic step(input string tag);
    #1;
    chk({tag, ".id_ready"}, 32'(id_ready), 32'(!stall));
    chk({tag, ".raddr1"},   32'(raddr1),   32'(id_inst[25:21]));
    chk({tag, ".raddr2"},   32'(raddr2),   32'(id_inst[20:16]));
    if (rst || flush) expd = bubble();
    else if (!stall)  expd = model();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic no_fwd();
    fw_ex_wreg = 0; fw_ex_waddr = 0; fw_ex_wdata = 0;
    fw_mem_wreg = 0; fw_mem_waddr = 0; fw_mem_wdata = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 8))
      0: return {6'o15, rs, rt, 16'($urandom)};
      1: return {6'o14, rs, rt, 16'($urandom)};
      2: return {6'o10, rs, rt, 16'($urandom)};
      3: return {6'o11, rs, rt, 16'($urandom)};
      4: return {6'o17, rs, rt, 16'($urandom)};
      5, 6: begin
        fn = 6'($urandom_range(6'o40, 6'o47));
        return {6'o00, rs, rt, rd, 5'd0, fn};
      end
      7: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    expd = bubble();
    rst = 1; stall = 1; flush = 0; id_valid = 1;
    id_inst = 32'h3422_8001; id_pc = 32'h100;
    rf_rdata1 = 0; rf_rdata2 = 0;
    no_fwd();

    // Reset for two cycles while stall is high.
    step("reset0");
    step("reset1");
    chk("reset.ex_pc_zero", ex_pc, 32'h0);

    rst = 0; stall = 0;
    id_inst = 32'h3422_8001; id_pc = 32'h104; rf_rdata1 = 32'h0000_00F0;
    step("ori");
    chk("ori.ext_imm_const", ext_imm, 32'h0000_8001);

    id_inst = 32'h2003_FFFF; id_pc = 32'h108; rf_rdata1 = 32'hDEAD_BEEF;
    step("addi");
    chk("addi.ext_imm_const", ext_imm, 32'hFFFF_FFFF);

    id_inst = 32'h3C24_1234; id_pc = 32'h10C;
    step("lui");
    chk("lui.ext_imm_const", ext_imm, 32'h1234_0000);

    // SUB $5,$6,$7: EX beats MEM on $6, MEM supplies $7.
    id_inst = 32'h00C7_2822; id_pc = 32'h110;
    rf_rdata1 = 32'h44; rf_rdata2 = 32'h44;
    fw_ex_wreg = 1; fw_ex_waddr = 6; fw_ex_wdata = 32'h11;
    fw_mem_wreg = 1; fw_mem_waddr = 6; fw_mem_wdata = 32'h22;
    step("sub_ex_over_mem");
    chk("sub.rdata1_const", rdata1, 32'h11);
    fw_mem_waddr = 7; fw_mem_wdata = 32'h33;
    step("sub_mem_rt");
    chk("sub.rdata2_const", rdata2, 32'h33);
    no_fwd();

    // Load ORI, then hold with a different instruction presented.
    id_inst = 32'h3422_8001; id_pc = 32'h114; rf_rdata1 = 32'hF0;
    step("ori_reload");
    stall = 1; id_inst = 32'h00C7_2822; id_pc = 32'h118; rf_rdata1 = 32'h55;
    for (int i = 0; i < 3; i++) step("stall_hold");
    chk("stall.ext_imm_held", ext_imm, 32'h0000_8001);
    flush = 1;
    step("flush_over_stall");
    flush = 0; stall = 0;

    id_inst = 32'hFC22_1234; id_pc = 32'h11C;
    step("illegal_op");
    id_inst = 32'h0000_002A;
    step("illegal_funct");
    id_inst = 32'h0;
    step("nop");
    id_inst = 32'h3420_0001;
    step("ori_to_r0");
    id_valid = 0; id_inst = 32'h3422_8001;
    step("invalid_slot");

    // Reset in the middle of a stall clears the register.
    id_valid = 1; step("pre_rst");
    stall = 1; rst = 1; step("rst_mid_stall");
    rst = 0; stall = 0;

    for (int n = 0; n < 300; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      id_valid  = ($urandom_range(0, 7) != 0);
      id_inst   = rand_inst();
      id_pc     = $urandom & 32'hFFFF_FFFC;
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      fw_ex_wreg   = 1'($urandom);
      fw_ex_waddr  = 5'($urandom_range(0, 7));
      fw_ex_wdata  = $urandom;
      fw_mem_wreg  = 1'($urandom);
      fw_mem_waddr = 5'($urandom_range(0, 7));
      fw_mem_wdata = $urandom;
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
